// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter.
// Holds the FSM state encoding, the grant-source tag and the burst counter width helper.
package imem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GNT_IF = 2'd1,
      ARB_GNT_DM = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_DM = 1'b1
   } arb_src_e;

   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/imem_port_arbiter_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
// Clear wins over increment; at_max forces the next contended grant to the fetch side.
module starve_counter
   import imem_port_arbiter_pkg::*;
#(
   parameter int MAX_DM_BURST = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int CW = cnt_width(MAX_DM_BURST);

   logic [CW-1:0] cnt_q;

   assign at_max = (cnt_q == CW'(MAX_DM_BURST));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (inc && !at_max)
         cnt_q <= cnt_q + CW'(1);
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-port SRAM between IF fetches and MEM data accesses over a req/ack link.
// Data wins ties unless MAX_DM_BURST data grants already went by while a fetch waited.
module imem_port_arbiter
   import imem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DM_BURST = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   input  logic              flush,
   output logic [DATA_W-1:0] ifInstr,
   output logic              ifValid,
   output logic              freeze,
   input  logic              dmReq,
   input  logic              dmWE,
   input  logic [ADDR_W-1:0] dmAddr,
   input  logic [DATA_W-1:0] dmWData,
   output logic [DATA_W-1:0] dmRData,
   output logic              dmReady,
   output logic              dmStall,
   output logic              memReq,
   output logic              memWE,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   input  logic              memAck
);

   arb_state_e        state_q;
   arb_src_e          src_q;
   logic              squash_q;
   logic [DATA_W-1:0] rdata_q;
   logic              memReq_q, memWE_q, ifValid_q, dmReady_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] memWData_q, ifInstr_q, dmRData_q;

   logic at_max, gnt_dm, gnt_if, cnt_inc, cnt_clr, arb_open;

   // The requester whose completion pulse is out still holds its request this cycle,
   // so no grant is issued until the pulse has been seen.
   always_comb begin
      arb_open = (state_q == ARB_IDLE) && !ifValid_q && !dmReady_q;
      gnt_dm   = arb_open && dmReq && (!ifReq || !at_max);
      gnt_if   = arb_open && !gnt_dm && ifReq && !flush;
      cnt_inc  = gnt_dm && ifReq;
      cnt_clr  = gnt_if || ((state_q == ARB_IDLE) && !ifReq);
   end

   starve_counter #(.MAX_DM_BURST(MAX_DM_BURST)) u_starve (
      .clock  (clock),
      .reset  (reset),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .at_max (at_max)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ARB_IDLE;
         src_q      <= SRC_IF;
         squash_q   <= 1'b0;
         rdata_q    <= '0;
         memReq_q   <= 1'b0;
         memWE_q    <= 1'b0;
         memAddr_q  <= '0;
         memWData_q <= '0;
         ifInstr_q  <= '0;
         ifValid_q  <= 1'b0;
         dmRData_q  <= '0;
         dmReady_q  <= 1'b0;
      end else begin
         ifValid_q <= 1'b0;
         dmReady_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (gnt_dm) begin
                  memReq_q   <= 1'b1;
                  memWE_q    <= dmWE;
                  memAddr_q  <= dmAddr;
                  memWData_q <= dmWData;
                  src_q      <= SRC_DM;
                  squash_q   <= 1'b0;
                  state_q    <= ARB_GNT_DM;
               end else if (gnt_if) begin
                  memReq_q   <= 1'b1;
                  memWE_q    <= 1'b0;
                  memAddr_q  <= ifAddr;
                  memWData_q <= '0;
                  src_q      <= SRC_IF;
                  squash_q   <= 1'b0;
                  state_q    <= ARB_GNT_IF;
               end
            end
            ARB_GNT_IF, ARB_GNT_DM: begin
               if (state_q == ARB_GNT_IF && flush)
                  squash_q <= 1'b1;
               if (memAck) begin
                  rdata_q  <= memRData;
                  memReq_q <= 1'b0;
                  state_q  <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               state_q <= ARB_IDLE;
               memWE_q <= 1'b0;
               if (src_q == SRC_DM) begin
                  dmReady_q <= 1'b1;
                  if (!memWE_q)
                     dmRData_q <= rdata_q;
               end else if (!squash_q && !flush) begin
                  ifValid_q <= 1'b1;
                  ifInstr_q <= rdata_q;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign memReq   = memReq_q;
   assign memWE    = memWE_q;
   assign memAddr  = memAddr_q;
   assign memWData = memWData_q;
   assign ifInstr  = ifInstr_q;
   assign ifValid  = ifValid_q;
   assign dmRData  = dmRData_q;
   assign dmReady  = dmReady_q;
   assign freeze   = ifReq & ~ifValid_q;
   assign dmStall  = dmReq & ~dmReady_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small variable-latency memory responder.
module tb_imem_port_arbiter;

   logic        clock, reset;
   logic        ifReq, flush, dmReq, dmWE, memAck;
   logic [31:0] ifAddr, dmAddr, dmWData, memRData;
   logic [31:0] ifInstr, dmRData, memAddr, memWData;
   logic        ifValid, freeze, dmReady, dmStall, memReq, memWE;

   int          n_chk = 0, n_fail = 0;
   logic        mem_auto = 1'b1;
   int          ack_dly  = 1;
   logic [31:0] mem_rdata = '0;
   localparam logic [31:0] CONT_DATA = 32'h5555_0000;

   imem_port_arbiter dut (
      .clock(clock), .reset(reset),
      .ifReq(ifReq), .ifAddr(ifAddr), .flush(flush),
      .ifInstr(ifInstr), .ifValid(ifValid), .freeze(freeze),
      .dmReq(dmReq), .dmWE(dmWE), .dmAddr(dmAddr), .dmWData(dmWData),
      .dmRData(dmRData), .dmReady(dmReady), .dmStall(dmStall),
      .memReq(memReq), .memWE(memWE), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .memAck(memAck)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory responder: raises memAck ack_dly cycles after it first sees memReq, for one cycle.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clock);
         #1;
         if (mem_auto) begin
            if (memAck) begin
               memAck = 1'b0;
               cnt    = 0;
            end else if (memReq) begin
               if (cnt >= ack_dly) begin
                  memAck   = 1'b1;
                  memRData = mem_rdata;
               end else
                  cnt++;
            end else
               cnt = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick; tick;
      n_chk++; if (memReq !== 1'b0)   begin n_fail++; $display("FAIL reset_memReq got %b want 0", memReq); end
      n_chk++; if (ifValid !== 1'b0)  begin n_fail++; $display("FAIL reset_ifValid got %b want 0", ifValid); end
      n_chk++; if (dmReady !== 1'b0)  begin n_fail++; $display("FAIL reset_dmReady got %b want 0", dmReady); end
      n_chk++; if (memAddr !== 32'h0) begin n_fail++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
      n_chk++; if (ifInstr !== 32'h0) begin n_fail++; $display("FAIL reset_ifInstr got %h want 0", ifInstr); end
      n_chk++; if (dmRData !== 32'h0) begin n_fail++; $display("FAIL reset_dmRData got %h want 0", dmRData); end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_fetch;
      logic [31:0] addr_seen, instr;
      int pulses, frz_bad, pulse_at;
      addr_seen = '0; instr = '0; pulses = 0; frz_bad = 0; pulse_at = -1;
      ifAddr = 32'h10; mem_rdata = 32'hE3A01005; ack_dly = 2; ifReq = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (memReq) addr_seen = memAddr;
         if (ifValid) begin
            pulses++;
            if (pulse_at < 0) begin pulse_at = i; instr = ifInstr; ifReq = 1'b0; end
         end else if (ifReq && !freeze) frz_bad++;
      end
      n_chk++; if (addr_seen !== 32'h10)     begin n_fail++; $display("FAIL fetch_memAddr got %h want 00000010", addr_seen); end
      n_chk++; if (instr !== 32'hE3A01005)   begin n_fail++; $display("FAIL fetch_ifInstr got %h want e3a01005", instr); end
      n_chk++; if (pulses != 1)              begin n_fail++; $display("FAIL fetch_pulses got %0d want 1", pulses); end
      n_chk++; if (pulse_at != 5)            begin n_fail++; $display("FAIL fetch_latency got %0d want 5", pulse_at); end
      n_chk++; if (frz_bad != 0)             begin n_fail++; $display("FAIL fetch_freeze_low got %0d want 0", frz_bad); end
      n_chk++; if (freeze !== 1'b0)          begin n_fail++; $display("FAIL fetch_freeze_end got %b want 0", freeze); end
   endtask

   task automatic test_read_write;
      logic [31:0] addr_seen, wd_seen;
      logic we_seen, got;
      int stall_bad;
      addr_seen = '0; we_seen = 1'b1; got = 1'b0; stall_bad = 0;
      dmAddr = 32'h40; dmWE = 1'b0; dmWData = 32'h0; mem_rdata = 32'h1234; ack_dly = 1; dmReq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (memReq) begin addr_seen = memAddr; we_seen = memWE; end
         if (dmReady && !got) begin got = 1'b1; dmReq = 1'b0; end
         else if (dmReq && !dmStall) stall_bad++;
      end
      n_chk++; if (!got)                   begin n_fail++; $display("FAIL rd_ready got 0 want 1"); end
      n_chk++; if (addr_seen !== 32'h40)   begin n_fail++; $display("FAIL rd_memAddr got %h want 00000040", addr_seen); end
      n_chk++; if (we_seen !== 1'b0)       begin n_fail++; $display("FAIL rd_memWE got %b want 0", we_seen); end
      n_chk++; if (dmRData !== 32'h1234)   begin n_fail++; $display("FAIL rd_dmRData got %h want 00001234", dmRData); end
      n_chk++; if (stall_bad != 0)         begin n_fail++; $display("FAIL rd_dmStall got %0d want 0", stall_bad); end
      we_seen = 1'b0; wd_seen = '0; got = 1'b0;
      dmAddr = 32'h44; dmWE = 1'b1; dmWData = 32'hAA; mem_rdata = 32'hDEADBEEF; dmReq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (memReq) begin we_seen = memWE; wd_seen = memWData; end
         if (dmReady && !got) begin got = 1'b1; dmReq = 1'b0; dmWE = 1'b0; end
      end
      n_chk++; if (!got)                   begin n_fail++; $display("FAIL wr_ready got 0 want 1"); end
      n_chk++; if (we_seen !== 1'b1)       begin n_fail++; $display("FAIL wr_memWE got %b want 1", we_seen); end
      n_chk++; if (wd_seen !== 32'hAA)     begin n_fail++; $display("FAIL wr_memWData got %h want 000000aa", wd_seen); end
      n_chk++; if (dmRData !== 32'h1234)   begin n_fail++; $display("FAIL wr_dmRData_kept got %h want 00001234", dmRData); end
   endtask

   task automatic test_contention;
      logic seq [0:10];
      logic prev;
      int n;
      prev = 1'b0; n = 0;
      ifAddr = 32'h100; dmAddr = 32'h200; dmWE = 1'b0; mem_rdata = CONT_DATA; ack_dly = 0;
      ifReq = 1'b1; dmReq = 1'b1;
      for (int i = 0; i < 300 && n < 11; i++) begin
         tick;
         if (memReq && !prev) begin seq[n] = (memAddr == 32'h200); n++; end
         prev = memReq;
      end
      ifReq = 1'b0; dmReq = 1'b0;
      for (int i = 0; i < 8; i++) tick;
      n_chk++; if (n != 11) begin n_fail++; $display("FAIL cont_grant_count got %0d want 11", n); end
      for (int k = 0; k < n; k++) begin
         logic exp_dm;
         exp_dm = !(k == 4 || k == 9);
         n_chk++;
         if (seq[k] !== exp_dm) begin
            n_fail++; $display("FAIL cont_grant_%0d got dm=%b want dm=%b", k, seq[k], exp_dm);
         end
      end
      n_chk++; if (ifInstr !== CONT_DATA) begin n_fail++; $display("FAIL cont_ifInstr got %h want %h", ifInstr, CONT_DATA); end
   endtask

   task automatic test_flush;
      int blk_bad, vld, waited;
      logic ack_seen, got;
      logic [31:0] addr_seen, instr;
      blk_bad = 0; vld = 0; ack_seen = 1'b0; got = 1'b0; waited = 0; addr_seen = '0; instr = '0;
      ifAddr = 32'h60; ifReq = 1'b1; flush = 1'b1;
      tick; if (memReq) blk_bad++;
      tick; if (memReq) blk_bad++;
      n_chk++; if (blk_bad != 0) begin n_fail++; $display("FAIL flush_idle_block got %0d grants want 0", blk_bad); end
      ack_dly = 3; mem_rdata = 32'hBAD00060; flush = 1'b0;
      while (!memReq && waited < 20) begin tick; waited++; end
      n_chk++; if (!memReq) begin n_fail++; $display("FAIL flush_grant_timeout got memReq=0 want 1"); end
      flush = 1'b1;
      tick;
      flush = 1'b0; ifReq = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (memAck) ack_seen = 1'b1;
         if (ifValid) vld++;
      end
      n_chk++; if (!ack_seen)             begin n_fail++; $display("FAIL flush_access_done got ack=0 want 1"); end
      n_chk++; if (vld != 0)              begin n_fail++; $display("FAIL flush_no_valid got %0d want 0", vld); end
      n_chk++; if (memReq !== 1'b0)       begin n_fail++; $display("FAIL flush_memReq_end got %b want 0", memReq); end
      n_chk++; if (ifInstr !== CONT_DATA) begin n_fail++; $display("FAIL flush_ifInstr_kept got %h want %h", ifInstr, CONT_DATA); end
      ifAddr = 32'h80; mem_rdata = 32'h0ABC0080; ack_dly = 1; ifReq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (memReq) addr_seen = memAddr;
         if (ifValid && !got) begin got = 1'b1; instr = ifInstr; ifReq = 1'b0; end
      end
      n_chk++; if (addr_seen !== 32'h80)  begin n_fail++; $display("FAIL refetch_memAddr got %h want 00000080", addr_seen); end
      n_chk++; if (instr !== 32'h0ABC0080) begin n_fail++; $display("FAIL refetch_ifInstr got %h want 0abc0080", instr); end
   endtask

   task automatic test_zero_wait;
      logic v1, v2, v3, r1, r2;
      ifAddr = 32'h90; mem_rdata = 32'h9090; ack_dly = 0; ifReq = 1'b1;
      tick; v1 = ifValid; r1 = memReq;
      tick; v2 = ifValid; r2 = memReq;
      tick; v3 = ifValid;
      n_chk++; if (v3 && ifInstr !== 32'h9090) begin n_fail++; $display("FAIL zw_ifInstr got %h want 00009090", ifInstr); end
      ifReq = 1'b0;
      n_chk++; if (r1 !== 1'b1)                 begin n_fail++; $display("FAIL zw_memReq_e1 got %b want 1", r1); end
      n_chk++; if (r2 !== 1'b0)                 begin n_fail++; $display("FAIL zw_memReq_e2 got %b want 0", r2); end
      n_chk++; if ({v1, v2, v3} !== 3'b001)     begin n_fail++; $display("FAIL zw_pulse_edges got %b want 001", {v1, v2, v3}); end
      for (int i = 0; i < 4; i++) tick;
   endtask

   task automatic test_reset_mid;
      int waited, rdy;
      logic rq;
      waited = 0; rdy = 0; rq = 1'b0;
      mem_auto = 1'b0; memAck = 1'b0;
      dmAddr = 32'h300; dmWE = 1'b0; dmReq = 1'b1;
      while (!memReq && waited < 10) begin tick; waited++; end
      n_chk++; if (!memReq) begin n_fail++; $display("FAIL rst_grant_timeout got memReq=0 want 1"); end
      tick;
      #1 reset = 1'b0; dmReq = 1'b0;
      #1;
      n_chk++; if (memReq !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_memReq got %b want 0", memReq); end
      n_chk++; if (memAddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_memAddr got %h want 0", memAddr); end
      n_chk++; if (dmRData !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dmRData got %h want 0", dmRData); end
      n_chk++; if (ifInstr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ifInstr got %h want 0", ifInstr); end
      tick;
      reset = 1'b1;
      memAck = 1'b1; memRData = 32'h777;
      tick;
      memAck = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (dmReady) rdy++;
         if (memReq) rq = 1'b1;
      end
      n_chk++; if (rdy != 0)  begin n_fail++; $display("FAIL rst_late_ack_ready got %0d want 0", rdy); end
      n_chk++; if (rq)        begin n_fail++; $display("FAIL rst_late_ack_memReq got 1 want 0"); end
      n_chk++; if (dmRData !== 32'h0) begin n_fail++; $display("FAIL rst_late_ack_dmRData got %h want 0", dmRData); end
      mem_auto = 1'b1;
   endtask

   initial begin
      ifReq = 1'b0; flush = 1'b0; dmReq = 1'b0; dmWE = 1'b0; memAck = 1'b0;
      ifAddr = '0; dmAddr = '0; dmWData = '0; memRData = '0;
      test_reset;
      test_fetch;
      test_read_write;
      test_contention;
      test_flush;
      test_zero_wait;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
